mul_pipe: RTL
=============

Name: mul_pipe

Overview:
- Parametrised, pipelined radix-4 Booth / carry-save multiplier with valid/ready handshakes on both sides, sitting in the EX stage of the integer pipeline.
- Supports four product modes: low word, signed high, unsigned high and signed×unsigned high. The full 2×WIDTH product is also exposed.
- Accepts one operation per cycle, stalls under downstream backpressure, and drops in-flight work on a pipeline flush.

Parameters:
- WIDTH, 32, operand width; even, ≥8.
- TAG_W, 5, width of the opaque tag (e.g. destination register) carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  2  product mode: 00 MUL (low word), 01 MULH (signed×signed high), 10 MULHU (unsigned×unsigned high), 11 MULHSU (signed x × unsigned y, high).
- in_x  in  WIDTH  multiplicand.
- in_y  in  WIDTH  multiplier.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_res  out  WIDTH  selected half of the product.
- out_prod  out  2*WIDTH  full product in the request's signedness.
- out_tag  out  TAG_W  tag of the presented result.

Behaviour:
- Reset: all stage valid bits clear, so out_valid=0. out_res, out_prod and out_tag reset to 0. in_ready=1 in the first cycle after reset deasserts. Reset asserted mid-operation discards everything, and no result is ever presented for it.
- Operand extension to WIDTH+1 bits:
  - x is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - y is sign-extended for MULH only.
  - MUL uses the MULH extension; the low word is identical either way.
- Booth encoding: WIDTH/2+1 radix-4 groups over the extended y. Each group selects 0, ±x or ±2x, all 2*WIDTH wide. −x is formed as ~x+1 on the extended operand.
- Reduction: 3:2 CSA tree to two 2*WIDTH vectors, all arithmetic modulo 2^(2*WIDTH).
- Stage S1, registered at the end of the acceptance cycle: operands are Booth-reduced to the sum/carry pair, which is latched with op and tag.
- Stage S2: final carry-propagate add of sum+carry. The product and the selected half (low for MUL, high otherwise) are latched into the output register.
- Latency: a request accepted in cycle N sets out_valid in cycle N+2 if unstalled.
- Handshakes:
  - A transfer occurs when valid&&ready are both high at a clock edge.
  - Each stage advances when its successor is empty or is transferring this cycle.
  - in_ready = !s1_valid || s1_advance. This is a combinational path from out_ready.
  - Full throughput is one operation per cycle.
  - With out_ready low, the pipeline fills (2 entries) and then in_ready drops. Held entries keep their values stable.
- Output stability: while out_valid && !out_ready, out_res, out_prod and out_tag hold their values.
- Flush:
  - Clears every stage valid bit at the next edge.
  - A request presented in the same cycle as flush is not accepted, and in_ready reads 0 while flush=1.
  - A result presented during flush is considered consumed only if out_ready is also high. In either case it is removed.
- Ordering: results emerge in acceptance order. Tags are never reordered or duplicated.

Optional Feature:
- Macro: MUL_PIPE_OUT_REG_EN.
- Defined: an extra output register stage S3 is inserted after S2 to meet timing, giving latency 3 and a 3-entry capacity. Handshake, flush and ordering rules apply per stage unchanged.
- Undefined: latency 2, exactly as above.

Decomposition:
- Package mul_pkg:
  - mul_op_e enum (MUL, MULH, MULHU, MULHSU).
  - Booth select encoding constants (ZERO, P1, P2, N1, N2).
  - Function computing the number of Booth groups from WIDTH.
- Sub-module mul_booth_tree: combinational, parametrised by WIDTH. Inputs are the extended x, the extended y and the signed-mode bits. Outputs are the sum and carry vectors. It contains the Booth encoders and the CSA tree.
- mul_pipe owns the stage registers, handshake, flush, final adder and result selection.

Test Plan (WIDTH=32):
- MULH signed: x=0x80000000, y=0x80000000 → out_prod=0x4000000000000000, out_res=0x40000000 two cycles after acceptance.
- MULHU/MUL: MULHU x=y=0xFFFFFFFF → out_prod=0xFFFFFFFE00000001, out_res=0xFFFFFFFE. The same operands with MUL → out_res=0x00000001.
- MULHSU: x=0xFFFFFFFF (−1), y=0xFFFFFFFF (unsigned) → out_prod=0xFFFFFFFF00000001, out_res=0xFFFFFFFF. MULH with the same operands → out_res=0x00000000.
- Backpressure: 5 back-to-back requests with tags 1..5 and out_ready=0. in_ready drops after 2 accepts, and out_res/out_tag hold tag 1 stable. Raising out_ready drains tags 1..5 in order with 1/cycle throughput.
- Flush: 2 ops in flight plus flush=1 with in_valid=1 → no out_valid in the following 3 cycles, and the concurrent request is not accepted. The next request completes normally with correct tag.
- Reset mid-op: rst pulsed asynchronously between edges with an op in S1 → out_valid=0 immediately and all outputs 0. A post-reset random regression of 10k ops in all modes matches the reference model.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined radix-4 Booth multiplier.
//
// Contents:
//   mul_op_e      product mode carried with each operation
//   Booth*        radix-4 Booth partial-product select codes
//   booth_groups  number of radix-4 groups needed for a WIDTH-bit operand
//   booth_sel     maps one overlapping 3-bit multiplier window to a select code
package mul_pkg;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,  // low word
    OpMulh   = 2'b01,  // signed x signed, high word
    OpMulhu  = 2'b10,  // unsigned x unsigned, high word
    OpMulhsu = 2'b11   // signed x unsigned, high word
  } mul_op_e;

  // Bit 2 marks a negative multiple so the encoder can share the +/- paths.
  localparam logic [2:0] BoothZero = 3'b000;
  localparam logic [2:0] BoothP1   = 3'b001;
  localparam logic [2:0] BoothP2   = 3'b010;
  localparam logic [2:0] BoothN1   = 3'b101;
  localparam logic [2:0] BoothN2   = 3'b110;

  // A WIDTH+1 bit two's-complement multiplier needs ceil((WIDTH+1)/2) groups.
  function automatic int unsigned booth_groups(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Window is {y[2i+1], y[2i], y[2i-1]}.
  function automatic logic [2:0] booth_sel(input logic [2:0] win);
    logic [2:0] sel;
    unique case (win)
      3'b000, 3'b111: sel = BoothZero;
      3'b001, 3'b010: sel = BoothP1;
      3'b011:         sel = BoothP2;
      3'b100:         sel = BoothN2;
      3'b101, 3'b110: sel = BoothN1;
      default:        sel = BoothZero;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mul_booth_tree.sv
// Combinational radix-4 Booth encoder plus 3:2 carry-save reduction.
//
// Ports:
//   x_i         WIDTH+1 bit multiplicand, already sign/zero extended
//   y_i         WIDTH+1 bit multiplier, already sign/zero extended
//   x_signed_i  fill value source for widening x to 2*WIDTH
//   y_signed_i  fill value source for the top Booth window of y
//   sum_o       redundant sum vector, 2*WIDTH bits
//   carry_o     redundant carry vector, 2*WIDTH bits
// sum_o + carry_o equals x*y modulo 2^(2*WIDTH).
module mul_booth_tree
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]     x_i,
  input  logic [WIDTH:0]     y_i,
  input  logic               x_signed_i,
  input  logic               y_signed_i,
  output logic [2*WIDTH-1:0] sum_o,
  output logic [2*WIDTH-1:0] carry_o
);

  localparam int unsigned NumGroups = booth_groups(WIDTH);
  localparam int unsigned PW        = 2 * WIDTH;

  logic [PW-1:0]    x_pos;
  logic [PW-1:0]    x_neg;
  logic [WIDTH+2:0] y_pad;
  logic [2:0]       sel;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_s;
  logic [PW-1:0]    acc_c;
  logic [PW-1:0]    maj;

  assign x_pos = {{(PW-WIDTH-1){x_signed_i & x_i[WIDTH]}}, x_i};
  assign x_neg = ~x_pos + 1'b1;
  // Implicit y[-1] = 0 at the bottom, one extra sign bit on top for the last window.
  assign y_pad = {y_signed_i & y_i[WIDTH], y_i, 1'b0};

  always_comb begin
    sel   = BoothZero;
    pp    = '0;
    acc_s = '0;
    acc_c = '0;
    maj   = '0;
    for (int i = 0; i < int'(NumGroups); i++) begin
      sel = booth_sel(y_pad[2*i +: 3]);
      unique case (sel)
        BoothP1: pp = x_pos;
        BoothP2: pp = x_pos << 1;
        BoothN1: pp = x_neg;
        BoothN2: pp = x_neg << 1;
        default: pp = '0;
      endcase
      pp = pp << (2 * i);
      // 3:2 compress the running pair with the new partial product.
      maj   = (acc_s & acc_c) | (acc_s & pp) | (acc_c & pp);
      acc_s = acc_s ^ acc_c ^ pp;
      acc_c = maj << 1;
    end
  end

  assign sum_o   = acc_s;
  assign carry_o = acc_c;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined radix-4 Booth multiplier with valid/ready handshakes on both sides.
//
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   flush_i         kills every in-flight operation at the next edge
//   in_valid_i/in_ready_o, in_op_i (mul_op_e), in_x_i, in_y_i, in_tag_i   request
//   out_valid_o/out_ready_i, out_res_o, out_prod_o, out_tag_o            result
//
// S1 latches the Booth sum/carry pair, S2 does the final add and holds the result.
// Define MUL_PIPE_OUT_REG_EN to add an output register stage S3 (latency 3).
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         in_op_i,
  input  logic [WIDTH-1:0]   in_x_i,
  input  logic [WIDTH-1:0]   in_y_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_res_o,
  output logic [2*WIDTH-1:0] out_prod_o,
  output logic [TAG_W-1:0]   out_tag_o
);

  localparam int unsigned PW = 2 * WIDTH;

  mul_op_e        in_op;
  logic           x_signed;
  logic           y_signed;
  logic [WIDTH:0] x_ext;
  logic [WIDTH:0] y_ext;
  logic [PW-1:0]  booth_sum;
  logic [PW-1:0]  booth_carry;

  // MUL shares the MULH extension; the low word does not depend on it.
  assign in_op    = mul_op_e'(in_op_i);
  assign x_signed = (in_op != OpMulhu);
  assign y_signed = (in_op == OpMul) || (in_op == OpMulh);
  assign x_ext    = {x_signed & in_x_i[WIDTH-1], in_x_i};
  assign y_ext    = {y_signed & in_y_i[WIDTH-1], in_y_i};

  mul_booth_tree #(
    .WIDTH(WIDTH)
  ) u_booth_tree (
    .x_i       (x_ext),
    .y_i       (y_ext),
    .x_signed_i(x_signed),
    .y_signed_i(y_signed),
    .sum_o     (booth_sum),
    .carry_o   (booth_carry)
  );

  // Stage registers.
  logic             s1_valid_q, s1_valid_d;
  logic [PW-1:0]    s1_sum_q;
  logic [PW-1:0]    s1_carry_q;
  mul_op_e          s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_prod_q;
  logic [WIDTH-1:0] s2_res_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [PW-1:0]    prod_sum;
  logic [WIDTH-1:0] res_sel;

  assign prod_sum = s1_sum_q + s1_carry_q;
  assign res_sel  = (s1_op_q == OpMul) ? prod_sum[WIDTH-1:0] : prod_sum[PW-1:WIDTH];

  // Handshake: a stage can take new data when empty or when its occupant leaves.
  logic s2_advance;
  logic s2_take;
  logic s1_advance;
  logic in_fire;

`ifdef MUL_PIPE_OUT_REG_EN
  logic             s3_valid_q, s3_valid_d;
  logic [PW-1:0]    s3_prod_q;
  logic [WIDTH-1:0] s3_res_q;
  logic [TAG_W-1:0] s3_tag_q;
  logic             s3_take;

  assign s3_take    = !s3_valid_q || out_ready_i;
  assign s2_advance = s2_valid_q && s3_take;
`else
  assign s2_advance = s2_valid_q && out_ready_i;
`endif

  assign s2_take    = !s2_valid_q || s2_advance;
  assign s1_advance = s1_valid_q && s2_take;
  assign in_ready_o = (!s1_valid_q || s1_advance) && !flush_i;
  assign in_fire    = in_valid_i && in_ready_o;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_d = 1'b1;
      end else if (s1_advance) begin
        s1_valid_d = 1'b0;
      end
      if (s1_advance) begin
        s2_valid_d = 1'b1;
      end else if (s2_advance) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s1_op_q    <= OpMul;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_sum_q   <= booth_sum;
        s1_carry_q <= booth_carry;
        s1_op_q    <= in_op;
        s1_tag_q   <= in_tag_i;
      end
      if (s1_advance) begin
        s2_prod_q <= prod_sum;
        s2_res_q  <= res_sel;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

`ifdef MUL_PIPE_OUT_REG_EN
  always_comb begin
    s3_valid_d = s3_valid_q;
    if (flush_i) begin
      s3_valid_d = 1'b0;
    end else if (s2_advance) begin
      s3_valid_d = 1'b1;
    end else if (out_ready_i) begin
      s3_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s3_valid_q <= 1'b0;
      s3_prod_q  <= '0;
      s3_res_q   <= '0;
      s3_tag_q   <= '0;
    end else begin
      s3_valid_q <= s3_valid_d;
      if (s2_advance) begin
        s3_prod_q <= s2_prod_q;
        s3_res_q  <= s2_res_q;
        s3_tag_q  <= s2_tag_q;
      end
    end
  end

  assign out_valid_o = s3_valid_q;
  assign out_prod_o  = s3_prod_q;
  assign out_res_o   = s3_res_q;
  assign out_tag_o   = s3_tag_q;
`else
  assign out_valid_o = s2_valid_q;
  assign out_prod_o  = s2_prod_q;
  assign out_res_o   = s2_res_q;
  assign out_tag_o   = s2_tag_q;
`endif

endmodule
